// File: rtl/fir_p2s_pkg.sv
// Shared constants, FSM encoding and sizing helper for the fir_p2s parallel-to-serial block.
package fir_p2s_pkg;

   localparam int LANES_DEF = 6;
   localparam int W_DEF     = 12;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      SHIFT      = 2'd1,
      SHIFT_PEND = 2'd2
   } state_t;

   // Bits needed to index n lanes.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_p2s_if.sv
// Block-in / word-out stream bundle of fir_p2s; slave is the converter, master is its environment.
interface fir_p2s_if #(
   parameter int LANES = fir_p2s_pkg::LANES_DEF,
   parameter int W     = fir_p2s_pkg::W_DEF
);
   logic               p_valid;
   logic [LANES*W-1:0] p_data;
   logic               s_valid;
   logic               s_ready;
   logic [W-1:0]       s_data;
   logic               s_first;
   logic               s_last;

   modport master (output p_valid, p_data, s_ready,
                   input  s_valid, s_data, s_first, s_last);
   modport slave  (input  p_valid, p_data, s_ready,
                   output s_valid, s_data, s_first, s_last);
endinterface

// File: rtl/fir_p2s_mux.sv
// Lane selector: picks word i_sel out of a packed block; out-of-range selects read as zero.
module fir_p2s_mux
   import fir_p2s_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF,
   parameter int IW    = clog2(LANES)
) (
   input  logic [LANES*W-1:0] i_sr,
   input  logic [IW-1:0]      i_sel,
   output logic [W-1:0]       o_data
);
   logic [W-1:0] w_lane [LANES];

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lane[g] = i_sr[g*W +: W];
   end

   // Widened compare keeps the range check correct when LANES is a power of two.
   assign o_data = ({1'b0, i_sel} < (IW+1)'(LANES)) ? w_lane[i_sel] : {W{1'b0}};
endmodule

// File: rtl/fir_p2s.sv
// Parallel-to-serial converter: one LANES-word block per p_valid, replayed lane 0 first with one block of buffering.
// Optional macro FIR_P2S_OVF_CNT_EN adds the saturating dropped-block counter o_ovf_cnt.
module fir_p2s
   import fir_p2s_pkg::*;
#(
   parameter int LANES = LANES_DEF,
   parameter int W     = W_DEF
) (
   input  logic     clk,
   input  logic     rstn,
   fir_p2s_if.slave bus,
   input  logic     i_ovf_clr,
   output logic     o_ovf
`ifdef FIR_P2S_OVF_CNT_EN
   ,
   output logic [15:0] o_ovf_cnt
`endif
);
   localparam int            IW   = clog2(LANES);
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   state_t             r_state;
   logic [LANES*W-1:0] r_sr;
   logic [LANES*W-1:0] r_pr;
   logic [IW-1:0]      r_cnt;
   logic               r_ovf;
   logic               w_beat;
   logic               w_last;
   logic               w_drop;
   logic [W-1:0]       w_data;

   assign w_beat = (r_state != IDLE) && bus.s_ready;
   assign w_last = w_beat && (r_cnt == LAST);
   assign w_drop = (r_state == SHIFT_PEND) && bus.p_valid && !w_last;

   // Block sequencing: load, lane advance and pending-block promotion.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_sr    <= {(LANES*W){1'b0}};
         r_pr    <= {(LANES*W){1'b0}};
         r_cnt   <= {IW{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.p_valid) begin
                  r_sr    <= bus.p_data;
                  r_cnt   <= {IW{1'b0}};
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               if (w_last) begin
                  r_cnt <= {IW{1'b0}};
                  if (bus.p_valid) begin
                     r_sr <= bus.p_data;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  if (w_beat) begin
                     r_cnt <= r_cnt + IW'(1);
                  end
                  if (bus.p_valid) begin
                     r_pr    <= bus.p_data;
                     r_state <= SHIFT_PEND;
                  end
               end
            end
            SHIFT_PEND: begin
               if (w_last) begin
                  r_sr  <= r_pr;
                  r_cnt <= {IW{1'b0}};
                  if (bus.p_valid) begin
                     r_pr <= bus.p_data;
                  end else begin
                     r_state <= SHIFT;
                  end
               end else if (w_beat) begin
                  r_cnt <= r_cnt + IW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= {IW{1'b0}};
            end
         endcase
      end
   end

   // Sticky drop flag; a new drop outranks a clear in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (i_ovf_clr) begin
         r_ovf <= 1'b0;
      end
   end

`ifdef FIR_P2S_OVF_CNT_EN
   logic [15:0] r_ovf_cnt;

   // Saturating dropped-block counter; increment outranks clear.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ovf_cnt <= 16'h0000;
      end else if (w_drop) begin
         if (r_ovf_cnt != 16'hFFFF) begin
            r_ovf_cnt <= r_ovf_cnt + 16'h0001;
         end
      end else if (i_ovf_clr) begin
         r_ovf_cnt <= 16'h0000;
      end
   end

   assign o_ovf_cnt = r_ovf_cnt;
`endif

   fir_p2s_mux #(
      .LANES (LANES),
      .W     (W),
      .IW    (IW)
   ) u_mux (
      .i_sr   (r_sr),
      .i_sel  (r_cnt),
      .o_data (w_data)
   );

   assign bus.s_valid = (r_state != IDLE);
   assign bus.s_data  = w_data;
   assign bus.s_first = (r_state != IDLE) && (r_cnt == {IW{1'b0}});
   assign bus.s_last  = (r_state != IDLE) && (r_cnt == LAST);
   assign o_ovf       = r_ovf;
endmodule

// File: tb/tb_fir_p2s.sv
// Directed self-checking bench for fir_p2s: single block, streaming, stall buffering, overflow and mid-block reset.
module tb_fir_p2s;
   localparam int LANES = 6;
   localparam int W     = 12;
   typedef logic [W-1:0]       word_t;
   typedef logic [LANES*W-1:0] blk_t;

   logic clk;
   logic rstn;
   logic ovf_clr;
   logic ovf;
`ifdef FIR_P2S_OVF_CNT_EN
   logic [15:0] ovf_cnt;
`endif
   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   fir_p2s_if #(.LANES(LANES), .W(W)) bus ();

   fir_p2s #(.LANES(LANES), .W(W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus),
      .i_ovf_clr (ovf_clr),
      .o_ovf     (ovf)
`ifdef FIR_P2S_OVF_CNT_EN
      ,
      .o_ovf_cnt (ovf_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input word_t w, input logic f, input logic l);
      chk({tag, ".valid"}, {31'd0, bus.s_valid}, 32'd1);
      chk({tag, ".data"},  {20'd0, bus.s_data},  {20'd0, w});
      chk({tag, ".first"}, {31'd0, bus.s_first}, {31'd0, f});
      chk({tag, ".last"},  {31'd0, bus.s_last},  {31'd0, l});
   endtask

   // Block whose lane k holds base+k.
   function automatic blk_t mk(input int base);
      blk_t b;
      for (int k = 0; k < LANES; k++) b[k*W +: W] = W'(base + k);
      return b;
   endfunction

   function automatic word_t lane(input blk_t b, input int k);
      return b[k*W +: W];
   endfunction

   task automatic chk_ovf(input string tag, input logic e, input int ecnt);
      chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e});
`ifdef FIR_P2S_OVF_CNT_EN
      chk({tag, ".ovf_cnt"}, {16'd0, ovf_cnt}, 32'(ecnt));
`else
      if (ecnt < 0) $display("unexpected negative count");
`endif
   endtask

   initial begin
      blk_t  a, b, c, d, blk;
      word_t q[$];
      word_t exp1 [LANES];
      exp1[0] = 12'h005; exp1[1] = 12'hFFD; exp1[2] = 12'h007;
      exp1[3] = 12'h000; exp1[4] = 12'hFF0; exp1[5] = 12'h00B;

      rstn = 1'b0; ovf_clr = 1'b0;
      bus.p_valid = 1'b0; bus.p_data = '0; bus.s_ready = 1'b0;
      tick(); tick();
      chk("rst.valid", {31'd0, bus.s_valid}, 32'd0);
      chk("rst.data",  {20'd0, bus.s_data},  32'd0);
      chk("rst.first", {31'd0, bus.s_first}, 32'd0);
      chk("rst.last",  {31'd0, bus.s_last},  32'd0);
      chk_ovf("rst", 1'b0, 0);
      rstn = 1'b1;
      tick();

      // Single block with signed lanes.
      bus.s_ready = 1'b1;
      bus.p_data  = {12'd11, -12'sd16, 12'd0, 12'd7, -12'sd3, 12'd5};
      bus.p_valid = 1'b1;
      tick();
      bus.p_valid = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         chk_word("one", exp1[k], k == 0, k == LANES - 1);
         tick();
      end
      chk("one.idle", {31'd0, bus.s_valid}, 32'd0);

      // 20 back-to-back random blocks, no gaps allowed.
      for (int cyc = 0; cyc < 20 * LANES; cyc++) begin
         if (cyc % LANES == 0) begin
            for (int k = 0; k < LANES; k++) begin
               blk[k*W +: W] = W'($urandom);
               q.push_back(blk[k*W +: W]);
            end
            bus.p_data  = blk;
            bus.p_valid = 1'b1;
         end else begin
            bus.p_valid = 1'b0;
         end
         tick();
         chk_word("stream", q.pop_front(), cyc % LANES == 0, cyc % LANES == LANES - 1);
      end
      bus.p_valid = 1'b0;
      tick();
      chk("stream.idle", {31'd0, bus.s_valid}, 32'd0);
      chk_ovf("stream", 1'b0, 0);

      // Stall: A held, B buffered, then both drain back-to-back.
      a = mk(12'h100); b = mk(12'h200);
      bus.s_ready = 1'b0;
      bus.p_data = a; bus.p_valid = 1'b1; tick();
      bus.p_valid = 1'b0; tick(); tick(); tick();
      bus.p_data = b; bus.p_valid = 1'b1; tick();
      bus.p_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk_word("hold", lane(a, 0), 1'b1, 1'b0);
      bus.s_ready = 1'b1;
      for (int k = 0; k < 2 * LANES; k++) begin
         chk_word("stall", (k < LANES) ? lane(a, k) : lane(b, k - LANES), k % LANES == 0, k % LANES == LANES - 1);
         tick();
      end
      chk("stall.idle", {31'd0, bus.s_valid}, 32'd0);
      chk_ovf("stall", 1'b0, 0);

      // Overflow: C dropped, D dropped with a simultaneous clear.
      c = mk(12'h300); d = mk(12'h400);
      bus.s_ready = 1'b0;
      bus.p_data = a; bus.p_valid = 1'b1; tick();
      bus.p_data = b; tick();
      bus.p_data = c; tick();
      bus.p_valid = 1'b0;
      chk_ovf("drop1", 1'b1, 1);
      bus.p_data = d; bus.p_valid = 1'b1; ovf_clr = 1'b1; tick();
      bus.p_valid = 1'b0; ovf_clr = 1'b0;
      chk_ovf("drop2", 1'b1, 2);
      bus.s_ready = 1'b1;
      for (int k = 0; k < 2 * LANES; k++) begin
         chk_word("ovfout", (k < LANES) ? lane(a, k) : lane(b, k - LANES), k % LANES == 0, k % LANES == LANES - 1);
         tick();
      end
      chk("ovfout.idle", {31'd0, bus.s_valid}, 32'd0);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      chk_ovf("clr", 1'b0, 0);

      // Load coincident with last beat, first with PR empty, then with PR full.
      bus.p_data = a; bus.p_valid = 1'b1; tick();
      bus.p_valid = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         chk_word("coA", lane(a, k), k == 0, k == LANES - 1);
         if (k == LANES - 1) begin
            bus.p_data = b; bus.p_valid = 1'b1;
         end
         tick();
         bus.p_valid = 1'b0;
      end
      chk_word("coB0", lane(b, 0), 1'b1, 1'b0);
      bus.s_ready = 1'b0;
      bus.p_data = c; bus.p_valid = 1'b1; tick();
      bus.p_valid = 1'b0; bus.s_ready = 1'b1;
      for (int k = 0; k < LANES; k++) begin
         chk_word("coB", lane(b, k), k == 0, k == LANES - 1);
         if (k == LANES - 1) begin
            bus.p_data = d; bus.p_valid = 1'b1;
         end
         tick();
         bus.p_valid = 1'b0;
      end
      for (int k = 0; k < 2 * LANES; k++) begin
         chk_word("coCD", (k < LANES) ? lane(c, k) : lane(d, k - LANES), k % LANES == 0, k % LANES == LANES - 1);
         tick();
      end
      chk("coCD.idle", {31'd0, bus.s_valid}, 32'd0);
      chk_ovf("co", 1'b0, 0);

      // Reset mid-block at lane 3.
      bus.p_data = c; bus.p_valid = 1'b1; tick();
      bus.p_valid = 1'b0;
      tick(); tick(); tick();
      chk_word("pre_rst", lane(c, 3), 1'b0, 1'b0);
      rstn = 1'b0;
      #1;
      chk("midrst.valid", {31'd0, bus.s_valid}, 32'd0);
      chk("midrst.data",  {20'd0, bus.s_data},  32'd0);
      chk("midrst.first", {31'd0, bus.s_first}, 32'd0);
      tick();
      rstn = 1'b1;
      tick();
      chk("post_rst.valid", {31'd0, bus.s_valid}, 32'd0);
      bus.p_data = d; bus.p_valid = 1'b1; tick();
      bus.p_valid = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         chk_word("post_rst", lane(d, k), k == 0, k == LANES - 1);
         tick();
      end
      chk("post_rst.idle", {31'd0, bus.s_valid}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
